pipe_stage_buf: RTL and testbench

//  Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_buf.sv | 113 +++++++++++
 tb/tb_pipe_stage_buf.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is decoded from state only, so no combinational ready path crosses the stage.
module pipe_stage_buf #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CTRL_W      = 32,
   parameter bit          ZERO_BUBBLE = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              acc, drn;

   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      occupancy = state_q;
      if (ZERO_BUBBLE && (state_q == EMPTY)) begin
         out_data = '0;
         out_ctrl = '0;
      end else begin
         out_data = main_data_q;
         out_ctrl = main_ctrl_q;
      end
   end

   assign acc = in_valid & in_ready;
   assign drn = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         // Flush wins: any input accepted this cycle is dropped with the held entries.
         state_d     = EMPTY;
         main_data_d = '0;
         main_ctrl_d = '0;
         skid_data_d = '0;
         skid_ctrl_d = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d     = HALF;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            HALF: begin
               if (acc && drn) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (acc) begin
                  state_d     = FULL;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (drn) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (drn) begin
                  state_d     = HALF;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and randomised checks of pipe_stage_buf; a second instance with
// ZERO_BUBBLE=0 shares the stimulus to observe bubble hold behaviour.
module tb_pipe_stage_buf;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;
   logic [31:0] in_ctrl;

   logic        in_ready, out_valid;
   logic [31:0] out_data, out_ctrl;
   logic [1:0]  occupancy;

   logic        in_ready_nb, out_valid_nb;
   logic [31:0] out_data_nb, out_ctrl_nb;
   logic [1:0]  occupancy_nb;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clock = ~clock;

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(32), .ZERO_BUBBLE(1'b1)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl),
      .occupancy(occupancy)
   );

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(32), .ZERO_BUBBLE(1'b0)) dut_nb (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_nb),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid_nb), .out_ready(out_ready),
      .out_data(out_data_nb), .out_ctrl(out_ctrl_nb),
      .occupancy(occupancy_nb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      in_valid = v;
      in_data  = d;
      in_ctrl  = d ^ 32'hC0DE_0000;
   endtask

   logic [31:0] exp_q[$];
   logic        rv, rr, racc, rdrn;
   logic [31:0] seq;

   initial begin
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0);
      #12;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_occ",   {30'b0, occupancy}, 32'd0);
      chk("rst_ready", {31'b0, in_ready},  32'd1);
      chk("rst_data",  out_data, 32'd0);
      reset = 1'b1;
      cyc();

      // Streaming 1..4 with out_ready high
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i));
         cyc();
         chk("stream_data", out_data, 32'(i));
         chk("stream_ctrl", out_ctrl, 32'(i) ^ 32'hC0DE_0000);
         chk("stream_occ",  {30'b0, occupancy}, 32'd1);
      end
      drive(1'b0, 32'h0);
      cyc();
      chk("stream_end_valid", {31'b0, out_valid}, 32'd0);
      chk("stream_end_zb",    out_data, 32'd0);
      chk("stream_end_nb",    out_data_nb, 32'd4);

      // Stall: A then B with out_ready low
      out_ready = 1'b0;
      drive(1'b1, 32'hA);
      cyc();
      chk("stall_a_occ", {30'b0, occupancy}, 32'd1);
      drive(1'b1, 32'hB);
      cyc();
      chk("stall_full_occ",   {30'b0, occupancy}, 32'd2);
      chk("stall_full_ready", {31'b0, in_ready},  32'd0);
      chk("stall_full_data",  out_data, 32'hA);
      drive(1'b0, 32'h0);
      cyc();
      chk("stall_hold_data", out_data, 32'hA);
      chk("stall_hold_ctrl", out_ctrl, 32'hA ^ 32'hC0DE_0000);
      out_ready = 1'b1;
      cyc();
      chk("stall_b_data",  out_data, 32'hB);
      chk("stall_b_ready", {31'b0, in_ready}, 32'd1);
      chk("stall_b_occ",   {30'b0, occupancy}, 32'd1);
      cyc();
      chk("stall_empty", {31'b0, out_valid}, 32'd0);

      // Flush while FULL, with C offered in the flush cycle
      out_ready = 1'b0;
      drive(1'b1, 32'h11);
      cyc();
      drive(1'b1, 32'h22);
      cyc();
      chk("flush_pre_occ", {30'b0, occupancy}, 32'd2);
      flush = 1'b1;
      drive(1'b1, 32'hC);
      cyc();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      chk("flush_occ",     {30'b0, occupancy}, 32'd0);
      chk("flush_valid",   {31'b0, out_valid}, 32'd0);
      chk("flush_ctrl",    out_ctrl, 32'd0);
      chk("flush_nb_data", out_data_nb, 32'd0);
      out_ready = 1'b1;
      cyc();
      chk("flush_no_c", {31'b0, out_valid}, 32'd0);

      // Flush in HALF discards an entry accepted in the same cycle
      drive(1'b1, 32'h33);
      out_ready = 1'b0;
      cyc();
      flush = 1'b1;
      drive(1'b1, 32'h44);
      cyc();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      chk("flush_half_occ", {30'b0, occupancy}, 32'd0);
      out_ready = 1'b1;
      cyc();
      chk("flush_half_no_d", {31'b0, out_valid}, 32'd0);

      // Bubble: drain last entry 0x55
      drive(1'b1, 32'h55);
      cyc();
      chk("bubble_present", out_data, 32'h55);
      drive(1'b0, 32'h0);
      cyc();
      chk("bubble_valid",   {31'b0, out_valid}, 32'd0);
      chk("bubble_nb_data", out_data_nb, 32'h55);
      chk("bubble_zb_data", out_data, 32'd0);

      // Asynchronous reset mid-stream while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h66);
      cyc();
      drive(1'b1, 32'h77);
      cyc();
      drive(1'b0, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_occ",   {30'b0, occupancy}, 32'd0);
      chk("arst_ready", {31'b0, in_ready},  32'd1);
      chk("arst_ctrl",  out_ctrl, 32'd0);
      #3;
      reset = 1'b1;
      cyc();

      // Randomised traffic against a FIFO reference model
      seq = 32'h1000;
      for (int n = 0; n < 4000; n++) begin
         chk("rnd_occ",   {30'b0, occupancy}, 32'(exp_q.size()));
         chk("rnd_ready", {31'b0, in_ready},  (exp_q.size() < 2) ? 32'd1 : 32'd0);
         chk("rnd_valid", {31'b0, out_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
         if (exp_q.size() != 0) begin
            chk("rnd_data", out_data, exp_q[0]);
            chk("rnd_ctrl", out_ctrl, exp_q[0] ^ 32'hC0DE_0000);
         end
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 2) != 0);
         out_ready = rr;
         drive(rv, seq);
         racc = rv && (exp_q.size() < 2);
         rdrn = rr && (exp_q.size() != 0);
         cyc();
         if (rdrn) void'(exp_q.pop_front());
         if (racc) begin
            exp_q.push_back(seq);
            seq = seq + 32'd1;
         end
      end
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("rnd_drained", {31'b0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
